// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier family:
// FSM state encodings and the operand sign/zero-extend helper.
package mult_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // Widest operand the extend helper supports; callers slice the low 2*WIDTH bits.
  localparam int unsigned MAX_WIDTH = 32;

  function automatic logic [2*MAX_WIDTH-1:0] extend_operand(
    input logic [MAX_WIDTH-1:0] value,
    input int unsigned          width,
    input logic                 sign_extend
  );
    logic                     fill;
    logic [2*MAX_WIDTH-1:0]   result;
    fill   = sign_extend & value[5'(width - 1)];
    result = {(2*MAX_WIDTH){fill}};
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        result[i] = value[i];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier, signed or unsigned, one
// multiplier bit retired per clock behind a 4-phase start/done handshake.
module seq_mult_param
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [CW-1:0]          count;
  logic                   mode_q;
  logic [PW-1:0]          a_q;
  logic [WIDTH-1:0]       b_q;
  logic [PW-1:0]          acc;
  logic [PW-1:0]          acc_next;
  logic [PW-1:0]          addend;
  logic                   last_step;
  logic [2*MAX_WIDTH-1:0] ext_full;
  logic [PW-1:0]          a_init;
  logic                   unused_ext;

  assign ext_full   = extend_operand(MAX_WIDTH'(data_a), WIDTH, signed_mode);
  assign a_init     = ext_full[PW-1:0];
  assign unused_ext = ^ext_full;

  // In signed mode the multiplier MSB carries negative weight, so the last step subtracts.
  always_comb begin
    state_next = state;
    last_step  = (count == LAST);
    addend     = b_q[0] ? a_q : '0;
    acc_next   = (last_step && mode_q) ? (acc - addend) : (acc + addend);
    case (state)
      IDLE:    if (start)     state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (!start)    state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      count   <= '0;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= signed_mode;
            a_q    <= a_init;
            b_q    <= data_b;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          count <= count + CW'(1);
          if (last_step) begin
            product <= acc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: directed corners at WIDTH=4 and 8 plus a
// randomized sweep against an arithmetic reference model.
module tb_seq_mult_param;

  logic        clock;
  logic        reset_n;

  logic        start_4, signed_4, busy_4, done_4;
  logic [3:0]  a_4, b_4;
  logic [7:0]  product_4;

  logic        start_8, signed_8, busy_8, done_8;
  logic [7:0]  a_8, b_8;
  logic [15:0] product_8;

  int compare_count  = 0;
  int mismatch_count = 0;

  seq_mult_param #(.WIDTH(4)) dut_4 (
    .clock(clock), .reset_n(reset_n), .start(start_4), .signed_mode(signed_4),
    .data_a(a_4), .data_b(b_4), .busy(busy_4), .done(done_4), .product(product_4)
  );

  seq_mult_param #(.WIDTH(8)) dut_8 (
    .clock(clock), .reset_n(reset_n), .start(start_8), .signed_mode(signed_8),
    .data_a(a_8), .data_b(b_8), .busy(busy_8), .done(done_8), .product(product_8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: interpret operands as w-bit integers, multiply, keep the low 2w bits.
  function automatic logic [15:0] ref_product(input int w, input logic sm, input logic [7:0] a, input logic [7:0] b);
    longint one = 1;
    longint ma, mb, p;
    ma = longint'(a) & ((one << w) - 1);
    mb = longint'(b) & ((one << w) - 1);
    if (sm && ma >= (one << (w - 1))) ma = ma - (one << w);
    if (sm && mb >= (one << (w - 1))) mb = mb - (one << w);
    p = (ma * mb) & ((one << (2 * w)) - 1);
    return 16'(p);
  endfunction

  function automatic logic get_done(input int w);
    return (w == 4) ? done_4 : done_8;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 4) ? busy_4 : busy_8;
  endfunction

  function automatic logic [15:0] get_product(input int w);
    return (w == 4) ? {8'h00, product_4} : product_8;
  endfunction

  task automatic drive(input int w, input logic st, input logic sm, input logic [7:0] a, input logic [7:0] b);
    if (w == 4) begin
      start_4 = st; signed_4 = sm; a_4 = a[3:0]; b_4 = b[3:0];
    end else begin
      start_8 = st; signed_8 = sm; a_8 = a; b_8 = b;
    end
  endtask

  // Edge count includes the capture edge; bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(input int w, inout int edges);
    while (!get_done(w) && edges < 40) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
  endtask

  // Called at a negedge: runs one full handshake, scrambling inputs while the DUT is busy.
  task automatic applyStimulus(input int w, input logic sm, input logic [7:0] a, input logic [7:0] b,
                               output logic [15:0] prod, output int edges);
    drive(w, 1'b1, sm, a, b);
    @(posedge clock);
    edges = 1;
    @(negedge clock);
    checkOutput("busy_after_capture", 32'(get_busy(w)), 32'd1);
    drive(w, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
    wait_done(w, edges);
    prod = get_product(w);
    drive(w, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
    @(posedge clock);
    @(negedge clock);
    checkOutput("done_after_drop", 32'(get_done(w)), 32'd0);
  endtask

  initial begin
    logic [15:0] prod;
    int          edges;
    logic [15:0] expected;
    int          w;
    logic        sm;
    logic [7:0]  a, b;

    reset_n = 1'b0;
    drive(4, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(8, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clock);
    checkOutput("reset_busy_4", 32'(busy_4), 32'd0);
    checkOutput("reset_done_4", 32'(done_4), 32'd0);
    checkOutput("reset_product_4", 32'(product_4), 32'd0);
    checkOutput("reset_product_8", 32'(product_8), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] directed W=4 cases");
    applyStimulus(4, 1'b1, 8'h05, 8'h0D, prod, edges);
    checkOutput("w4_s_5x-3", 32'(prod), 32'h00F1);
    checkOutput("w4_latency", 32'(edges), 32'd5);
    applyStimulus(4, 1'b0, 8'h0F, 8'h0F, prod, edges);
    checkOutput("w4_u_FxF", 32'(prod), 32'h00E1);
    applyStimulus(4, 1'b1, 8'h0F, 8'h0F, prod, edges);
    checkOutput("w4_s_-1x-1", 32'(prod), 32'h0001);
    applyStimulus(4, 1'b1, 8'h08, 8'h08, prod, edges);
    checkOutput("w4_s_-8x-8", 32'(prod), 32'h0040);
    applyStimulus(4, 1'b1, 8'h08, 8'h07, prod, edges);
    checkOutput("w4_s_-8x7", 32'(prod), 32'h00C8);
    applyStimulus(4, 1'b1, 8'h00, 8'h0F, prod, edges);
    checkOutput("w4_s_0x-1", 32'(prod), 32'h0000);

    $display("[TB] start held through DONE");
    drive(4, 1'b1, 1'b1, 8'h03, 8'h02);
    edges = 0;
    wait_done(4, edges);
    checkOutput("hold_first_done", 32'(done_4), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(4, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
      @(posedge clock);
      @(negedge clock);
      checkOutput("hold_done", 32'(done_4), 32'd1);
      checkOutput("hold_busy", 32'(busy_4), 32'd0);
      checkOutput("hold_product", 32'(product_4), 32'h06);
    end
    drive(4, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clock);
    @(negedge clock);
    checkOutput("drop_done", 32'(done_4), 32'd0);
    checkOutput("idle_product_kept", 32'(product_4), 32'h06);
    drive(4, 1'b1, 1'b1, 8'h0E, 8'h03);
    @(posedge clock);
    @(negedge clock);
    checkOutput("recapture_busy", 32'(busy_4), 32'd1);
    checkOutput("recapture_product_kept", 32'(product_4), 32'h06);
    edges = 1;
    wait_done(4, edges);
    checkOutput("recapture_result", 32'(product_4), 32'hFA);
    drive(4, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clock);
    @(negedge clock);

    $display("[TB] reset during RUN");
    drive(4, 1'b1, 1'b1, 8'h07, 8'h03);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    drive(4, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkOutput("abort_busy", 32'(busy_4), 32'd0);
    checkOutput("abort_done", 32'(done_4), 32'd0);
    checkOutput("abort_product", 32'(product_4), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    applyStimulus(4, 1'b1, 8'h07, 8'h03, prod, edges);
    checkOutput("after_abort", 32'(prod), 32'h0015);

    $display("[TB] directed W=8 case");
    applyStimulus(8, 1'b1, 8'h7F, 8'h80, prod, edges);
    checkOutput("w8_s_127x-128", 32'(prod), 32'hC080);
    checkOutput("w8_latency", 32'(edges), 32'd9);

    $display("[TB] random sweep");
    for (int n = 0; n < 1000; n++) begin
      w  = ($urandom_range(0, 1) == 1) ? 8 : 4;
      sm = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      b  = 8'($urandom);
      expected = ref_product(w, sm, a, b);
      applyStimulus(w, sm, a, b, prod, edges);
      checkOutput("random_product", 32'(prod), 32'(expected));
      checkOutput("random_latency", 32'(edges), 32'(w + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
